// File: rtl/i2s_mix_sched.sv
// i2s_mix_sched: once per i2s frame, polls NSRC sound sources in turn over a
// one-hot req/ack handshake. Each sample is scaled by its gain, accumulated,
// saturated to 24 bits and committed as the held sample for the i2s serializer.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   lrclk               word clock returned from i2s; a rising edge starts a frame
//   src_req/src_ack     one-hot request per source; ack qualifies that source's src_data slice
//   src_data            NSRC signed 16-bit samples, source i at [16i+15:16i]
//   cfg_we/addr/wdata   addr 0..NSRC-1: gain (128 = unity); addr 7: bit0 mute, bit1 clear flags
//   sound_out           committed signed 24-bit sample, held between commits
//   busy                a polling sequence is in progress
//   timeout_flag        sticky per-source missed-ack flags
//   overrun             sticky: lrclk rose while a sequence was still running
//
// Keep NSRC*(TIMEOUT+2)+4 <= 60 so the commit lands before the next left-slot load.
module i2s_mix_sched #(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lrclk,
    output logic [NSRC-1:0]      src_req,
    input  logic [NSRC-1:0]      src_ack,
    input  logic [16*NSRC-1:0]   src_data,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [23:0]          sound_out,
    output logic                 busy,
    output logic [NSRC-1:0]      timeout_flag,
    output logic                 overrun
);
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_NEXT, S_COMMIT} state_t;

    localparam logic [2:0]         LAST_IDX = 3'(NSRC - 1);
    localparam logic [3:0]         WCNT_MAX = 4'(TIMEOUT - 1);
    localparam logic signed [28:0] SAT_HI   = 29'sd8388607;
    localparam logic signed [28:0] SAT_LO   = -29'sd8388608;

    state_t                  state_q, state_d;
    logic                    lrclk_dly_q, lrclk_dly_d;
    logic [2:0]              idx_q, idx_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic signed [28:0]      acc_q, acc_d;
    logic signed [15:0]      smp_q, smp_d;
    logic [7:0]              sgain_q, sgain_d;
    logic [NSRC-1:0][7:0]    gain_q, gain_d;
    logic [NSRC-1:0]         req_q, req_d;
    logic [NSRC-1:0]         flag_q, flag_d;
    logic                    ovr_q, ovr_d;
    logic                    mute_q, mute_d;
    logic [23:0]             sound_q, sound_d;

    logic                    start;
    logic                    cur_ack;
    logic signed [15:0]      cur_data;
    logic [7:0]              cur_gain;
    logic [NSRC-1:0]         idx_hot;
    logic signed [24:0]      prod;
    logic signed [25:0]      term;
    logic [23:0]             sat_val;

    assign start = lrclk & ~lrclk_dly_q;

    // Per-source views of the currently indexed source.
    always_comb begin
        cur_ack  = 1'b0;
        cur_data = '0;
        cur_gain = '0;
        idx_hot  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (idx_q == 3'(i)) begin
                cur_ack    = src_ack[i];
                cur_data   = src_data[16*i +: 16];
                cur_gain   = gain_q[i];
                idx_hot[i] = 1'b1;
            end
        end
    end

    // Gain is unsigned Q1.7, so (sample*gain)<<1 puts unity at sample<<8.
    always_comb begin
        prod = 25'(smp_q) * 25'($signed({1'b0, sgain_q}));
        term = {prod, 1'b0};
    end

    always_comb begin
        if (acc_q > SAT_HI)      sat_val = 24'h7FFFFF;
        else if (acc_q < SAT_LO) sat_val = 24'h800000;
        else                     sat_val = acc_q[23:0];
    end

    always_comb begin
        state_d     = state_q;
        lrclk_dly_d = lrclk;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        acc_d       = acc_q;
        smp_d       = smp_q;
        sgain_d     = sgain_q;
        gain_d      = gain_q;
        req_d       = req_q;
        flag_d      = flag_q;
        ovr_d       = ovr_q;
        mute_d      = mute_q;
        sound_d     = sound_q;

        // Clears are applied first so a set in the same cycle wins.
        if (cfg_we) begin
            if (cfg_addr == 3'd7) begin
                mute_d = cfg_wdata[0];
                if (cfg_wdata[1]) begin
                    flag_d = '0;
                    ovr_d  = 1'b0;
                end
            end else begin
                for (int i = 0; i < NSRC; i++)
                    if (cfg_addr == 3'(i)) gain_d[i] = cfg_wdata;
            end
        end

        if (start && state_q != S_IDLE) ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                sgain_d = cur_gain;
                wcnt_d  = '0;
                if (cur_gain == 8'd0) begin
                    smp_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    req_d   = idx_hot;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cur_ack) begin
                    smp_d   = cur_data;
                    req_d   = '0;
                    state_d = S_NEXT;
                end else if (wcnt_q == WCNT_MAX) begin
                    smp_d   = '0;
                    req_d   = '0;
                    flag_d  = flag_d | idx_hot;
                    state_d = S_NEXT;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_NEXT: begin
                acc_d = acc_q + 29'(term);
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SEL;
                end
            end
            S_COMMIT: begin
                sound_d = mute_q ? 24'd0 : sat_val;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lrclk_dly_q <= 1'b0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            acc_q       <= '0;
            smp_q       <= '0;
            sgain_q     <= '0;
            gain_q      <= {NSRC{8'd128}};
            req_q       <= '0;
            flag_q      <= '0;
            ovr_q       <= 1'b0;
            mute_q      <= 1'b0;
            sound_q     <= '0;
        end else begin
            state_q     <= state_d;
            lrclk_dly_q <= lrclk_dly_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            acc_q       <= acc_d;
            smp_q       <= smp_d;
            sgain_q     <= sgain_d;
            gain_q      <= gain_d;
            req_q       <= req_d;
            flag_q      <= flag_d;
            ovr_q       <= ovr_d;
            mute_q      <= mute_d;
            sound_q     <= sound_d;
        end
    end

    assign src_req      = req_q;
    assign sound_out    = sound_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_flag = flag_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_mix_sched.sv
// Bench for i2s_mix_sched: behavioural frame model (per-source schedule and
// integer mix sum computed when a frame starts) compared every cycle, plus
// directed frames with hand-computed expectations and a randomized phase.
module tb_i2s_mix_sched;
    localparam int NSRC    = 4;
    localparam int TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 lrclk = 1'b0;
    logic [NSRC-1:0]      src_req;
    logic [NSRC-1:0]      src_ack;
    logic [16*NSRC-1:0]   src_data;
    logic                 cfg_we = 1'b0;
    logic [2:0]           cfg_addr = '0;
    logic [7:0]           cfg_wdata = '0;
    logic [23:0]          sound_out;
    logic                 busy;
    logic [NSRC-1:0]      timeout_flag;
    logic                 overrun;

    i2s_mix_sched #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(rst), .lrclk(lrclk),
        .src_req(src_req), .src_ack(src_ack), .src_data(src_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .sound_out(sound_out), .busy(busy), .timeout_flag(timeout_flag), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- sources ----------------
    int              sdata[NSRC];
    int              ack_dly[NSRC];   // cycles of req before ack; >= TIMEOUT means never
    int              hc[NSRC];
    logic [NSRC-1:0] ack_r = '0;
    bit              noise_en = 1'b0;

    for (genvar g = 0; g < NSRC; g++) begin : g_pack
        assign src_data[16*g +: 16] = 16'(sdata[g]);
    end
    assign src_ack = ack_r;

    always @(negedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (src_req[i]) begin
                ack_r[i] = (hc[i] == ack_dly[i]);
                hc[i]++;
            end else begin
                hc[i]    = 0;
                ack_r[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Observation counters used by directed tests.
    int req_cnt[NSRC];
    int falls = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        for (int i = 0; i < NSRC; i++) if (src_req[i]) req_cnt[i]++;
        if (prev_busy && !busy) falls++;
        prev_busy = busy;
    end

    // ---------------- what the DUT saw at each edge ----------------
    logic       lr_now, lr_prev, w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_now <= 1'b0; lr_prev <= 1'b0; w_we <= 1'b0; w_addr <= '0; w_data <= '0;
        end else begin
            lr_prev <= lr_now; lr_now <= lrclk;
            w_we <= cfg_we; w_addr <= cfg_addr; w_data <= cfg_wdata;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    function automatic logic [23:0] sat(input int v);
        if (v > 8388607)  return 24'h7FFFFF;
        if (v < -8388608) return 24'h800000;
        return v[23:0];
    endfunction

    bit              m_busy, m_mute, e_ovr;
    int              m_gain[NSRC];
    int              rq_from[NSRC], rq_to[NSRC], fl_edge[NSRC];
    int              commit_edge, m_sum, t_m, len_m;
    logic [23:0]     e_sound;
    logic [NSRC-1:0] e_flag, e_req;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_mute = 1'b0; e_ovr = 1'b0; e_sound = '0; e_flag = '0;
            commit_edge = -1;
            for (int i = 0; i < NSRC; i++) begin
                m_gain[i] = 128; rq_from[i] = -1; rq_to[i] = -2; fl_edge[i] = -1;
            end
        end else begin
            if (w_we) begin
                if (w_addr == 3'd7) begin
                    m_mute = w_data[0];
                    if (w_data[1]) begin e_flag = '0; e_ovr = 1'b0; end
                end else if (int'(w_addr) < NSRC) begin
                    m_gain[w_addr] = int'(w_data);
                end
            end
            if (lr_now && !lr_prev) begin
                if (m_busy) e_ovr = 1'b1;
                else begin
                    // Lay out the whole frame: each polled source costs SEL + req cycles + NEXT.
                    m_busy = 1'b1; m_sum = 0; t_m = cyc;
                    for (int i = 0; i < NSRC; i++) begin
                        rq_from[i] = -1; rq_to[i] = -2; fl_edge[i] = -1;
                        if (m_gain[i] == 0) t_m += 2;
                        else begin
                            len_m = (ack_dly[i] < TIMEOUT) ? ack_dly[i] + 1 : TIMEOUT;
                            rq_from[i] = t_m + 1;
                            rq_to[i]   = t_m + len_m;
                            if (ack_dly[i] < TIMEOUT) m_sum += sdata[i] * m_gain[i] * 2;
                            else fl_edge[i] = t_m + 1 + len_m;
                            t_m += len_m + 2;
                        end
                    end
                    commit_edge = t_m + 1;
                end
            end
            for (int i = 0; i < NSRC; i++) if (cyc == fl_edge[i]) e_flag[i] = 1'b1;
            if (m_busy && cyc == commit_edge) begin
                e_sound = m_mute ? 24'd0 : sat(m_sum);
                m_busy  = 1'b0;
            end
        end
        for (int i = 0; i < NSRC; i++) e_req[i] = m_busy && cyc >= rq_from[i] && cyc <= rq_to[i];
        check("sound_out", 32'(sound_out), 32'(e_sound));
        check("busy", 32'(busy), 32'(m_busy));
        check("src_req", 32'(src_req), 32'(e_req));
        check("timeout_flag", 32'(timeout_flag), 32'(e_flag));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("req_onehot", 32'($onehot0(src_req)), 32'd1);
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic frame(input int hi, input int lo);
        lrclk = 1'b1; wait_cyc(hi);
        lrclk = 1'b0; wait_cyc(lo);
    endtask

    task automatic set_all(input int d, input int dly);
        for (int i = 0; i < NSRC; i++) begin sdata[i] = d; ack_dly[i] = dly; end
    endtask

    initial begin
        int m0, r0, f0;
        set_all(0, 0);
        #1 rst = 1'b1;
        wait_cyc(3);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_sound", 32'(sound_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(src_req), 32'd0);
        check("rst_flags", 32'(timeout_flag), 32'd0);

        // 1: unity gain, immediate acks, 0x1000 each
        set_all(32'h1000, 0);
        lrclk = 1'b1; m0 = cyc;
        @(negedge clk); check("t1_req_lat1", 32'(src_req), 32'd0);
        @(negedge clk); check("t1_req_first", 32'(src_req), 32'b0001);
        wait_cyc(11);   // cyc = m0+13, commit cycle
        check("t1_pre_commit", 32'(sound_out), 32'd0);
        check("t1_busy_pre", 32'(busy), 32'd1);
        @(negedge clk); // cyc = m0+14
        check("t1_commit", 32'(sound_out), 32'h400000);
        check("t1_busy_post", 32'(busy), 32'd0);
        wait_cyc(20); lrclk = 1'b0; wait_cyc(30);

        // 2: saturation both ways
        for (int i = 0; i < NSRC; i++) cfg_write(3'(i), 8'd255);
        set_all(32767, 0);
        frame(40, 30);
        check("t2_sat_hi", 32'(sound_out), 32'h7FFFFF);
        set_all(-32768, 0);
        frame(40, 30);
        check("t2_sat_lo", 32'(sound_out), 32'h800000);

        // 3: source 2 never acks
        for (int i = 0; i < NSRC; i++) cfg_write(3'(i), 8'd128);
        set_all(32'h1000, 0); ack_dly[2] = 99;
        r0 = req_cnt[2];
        frame(40, 30);
        check("t3_req2_len", 32'(req_cnt[2] - r0), 32'd8);
        check("t3_flag", 32'(timeout_flag), 32'b0100);
        check("t3_sum", 32'(sound_out), 32'h300000);
        cfg_write(3'd7, 8'h02);
        check("t3_clear", 32'(timeout_flag), 32'd0);

        // 4: zero gain skips, mute zeroes the commit
        ack_dly[2] = 0;
        cfg_write(3'd1, 8'd0);
        r0 = req_cnt[1];
        frame(40, 30);
        check("t4_no_req1", 32'(req_cnt[1] - r0), 32'd0);
        check("t4_sum", 32'(sound_out), 32'h300000);
        cfg_write(3'd7, 8'h01);
        f0 = falls;
        frame(40, 30);
        check("t4_mute", 32'(sound_out), 32'd0);
        check("t4_busy_toggle", 32'(falls - f0), 32'd1);
        cfg_write(3'd7, 8'h00);
        cfg_write(3'd1, 8'd128);

        // 5: lrclk rises again mid-sequence
        set_all(32'h0100, 3);
        f0 = falls;
        lrclk = 1'b1; wait_cyc(3); lrclk = 1'b0; wait_cyc(3);
        frame(40, 30);
        check("t5_overrun", 32'(overrun), 32'd1);
        check("t5_one_commit", 32'(falls - f0), 32'd1);
        check("t5_sum", 32'(sound_out), 32'h040000);
        cfg_write(3'd7, 8'h02);
        check("t5_ovr_clear", 32'(overrun), 32'd0);

        // 6: reset while waiting on an ack
        set_all(32'h0100, 6);
        lrclk = 1'b1; wait_cyc(4);
        check("t6_in_wait", 32'(src_req), 32'b0001);
        #2 rst = 1'b1;
        #1;
        check("t6_req_abort", 32'(src_req), 32'd0);
        check("t6_busy_abort", 32'(busy), 32'd0);
        check("t6_sound_abort", 32'(sound_out), 32'd0);
        lrclk = 1'b0;
        @(negedge clk); wait_cyc(2);
        #2 rst = 1'b0;
        @(negedge clk);
        set_all(32'h0100, 0);
        frame(40, 30);
        check("t6_clean", 32'(sound_out), 32'h040000);

        // randomized frames
        noise_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NSRC; i++) begin
                int r;
                r = $urandom_range(0, 99);
                cfg_write(3'(i), (r < 20) ? 8'd0 : (r < 40) ? 8'd128 : 8'($urandom_range(1, 255)));
                sdata[i]   = int'($urandom_range(0, 65535)) - 32768;
                ack_dly[i] = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 9));
            end
            cfg_write(3'd7, {6'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0)});
            if (f % 7 == 3) begin
                lrclk = 1'b1; wait_cyc(2); lrclk = 1'b0; wait_cyc(2);
            end
            frame(46, 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
